i1_router_out_arb: RTL and testbench

I1_ROUTER_OUT_ARB -- requirements
Module: i1_router_out_arb

---
 rtl/i1_router_out_arb.sv | 151 +++++++++++++++
 tb/tb_i1_router_out_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i1_router_out_arb.sv
// i1_router_out_arb: round-robin output-port arbiter for a 4-input router.
// A requester wins the output when its FIFO front is a head flit (001) and
// keeps it until its tail flit (110) is read. Grants do not overlap: the
// requester that was just served gets the lowest priority in the next
// arbitration.
// Optional feature: define I1_ROUTER_ARB_TIMEOUT_EN to add a stall watchdog.
// The watchdog force-releases a grant after TIMEOUT consecutive BUSY cycles
// without a read, and then pulses timeout_err for one cycle.
`timescale 1ns/1ps

module i1_router_out_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  fifo_empty,
    input  logic [11:0] fifo_head,
    input  logic        out_busy,
    output logic [3:0]  fifo_rd,
    output logic        out_req,
    output logic [1:0]  out_sel,
    output logic        grant_valid,
    output logic        timeout_err
);

    localparam logic [2:0] FlitHead = 3'b001;
    localparam logic [2:0] FlitTail = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [1:0] sel_q;

    logic [2:0] headType [4];
    logic [3:0] eligible;
    logic       grant_d;
    logic [1:0] sel_d;
    logic       readFire;
    logic       tailRead;

    // Unpack each requester's front-flit type and decide whether it can bid.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            headType[i] = fifo_head[3*i +: 3];
            eligible[i] = ~fifo_empty[i] & (headType[i] == FlitHead);
        end
    end

    // Round-robin search from ptr+1 up to ptr. Scanning from the far end keeps the nearest eligible requester.
    always_comb begin
        grant_d = 1'b0;
        sel_d   = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (eligible[ptr_q + 2'(k)]) begin
                grant_d = 1'b1;
                sel_d   = ptr_q + 2'(k);
            end
        end
    end

    assign grant_valid = (state_q == BUSY);
    assign out_sel     = sel_q;
    assign out_req     = grant_valid & ~fifo_empty[sel_q];
    assign readFire    = out_req & ~out_busy;
    assign fifo_rd     = readFire ? (4'b0001 << sel_q) : 4'b0000;
    assign tailRead    = readFire & (headType[sel_q] == FlitTail);

`ifdef I1_ROUTER_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic       terr_q;

    assign timeout_err = terr_q;

    // Arbitration FSM with stall watchdog. A forced release behaves like a tail: the owner drops to lowest priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            cnt_q   <= 8'd0;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (grant_d) begin
                        sel_q   <= sel_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (readFire) begin
                        cnt_q <= 8'd0;
                        if (tailRead) begin
                            state_q <= IDLE;
                            ptr_q   <= sel_q;
                        end
                    end else if (cnt_q == TimeoutLast) begin
                        state_q <= IDLE;
                        ptr_q   <= sel_q;
                        cnt_q   <= 8'd0;
                        terr_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    logic unusedTimeout;

    // Without the watchdog the grant is only released by a tail, and TIMEOUT has no effect.
    assign unusedTimeout = ^(8'(TIMEOUT));
    assign timeout_err   = 1'b0;

    // Arbitration FSM: grant on a head flit, release on the tail read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        sel_q   <= sel_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (tailRead) begin
                        state_q <= IDLE;
                        ptr_q   <= sel_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_i1_router_out_arb.sv
// tb_i1_router_out_arb: self-checking bench for i1_router_out_arb.
// Four flit queues act as the requester FIFOs. A packet-level reference model
// tracks the owner, the last served requester and the stall count, and every
// DUT output is compared against it on each negative clock edge.
// Directed scenarios pin specific expected values, and a randomized phase
// follows them. Define I1_ROUTER_ARB_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps

module tb_i1_router_out_arb;

    localparam int TB_TIMEOUT = 4;
`ifdef I1_ROUTER_ARB_TIMEOUT_EN
    localparam int BP_CYCLES = 3;
`else
    localparam int BP_CYCLES = 5;
`endif

    typedef logic [2:0] flit_t;

    logic        clk;
    logic        rst;
    logic [3:0]  fifo_empty;
    logic [11:0] fifo_head;
    logic        out_busy;
    logic [3:0]  fifo_rd;
    logic        out_req;
    logic [1:0]  out_sel;
    logic        grant_valid;
    logic        timeout_err;

    i1_router_out_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_head   (fifo_head),
        .out_busy    (out_busy),
        .fifo_rd     (fifo_rd),
        .out_req     (out_req),
        .out_sel     (out_sel),
        .grant_valid (grant_valid),
        .timeout_err (timeout_err)
    );

    flit_t fq [4][$];
    int    checks = 0;
    int    errors = 0;
    int    hideMode = 0;
    int    busyMode = 0;

    int    owner = -1;
    int    lastServed = 3;
    int    selHeld = 0;
    int    stall = 0;
    bit    terrExp = 1'b0;

    int    rdCount [4] = '{0, 0, 0, 0};
    int    timeoutSeen = 0;
    bit    prevGrant = 1'b0;
    int    grantLog [$];
    int    modelLog [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveInputs();
        for (int r = 0; r < 4; r++) begin
            bit hidden;
            hidden = (hideMode != 0) && ($urandom_range(0, 4) == 0);
            fifo_empty[r] = (fq[r].size() == 0) || hidden;
            fifo_head[3*r +: 3] = (fq[r].size() != 0) ? fq[r][0] : 3'b000;
        end
        if (busyMode == 2)      out_busy = 1'b1;
        else if (busyMode == 1) out_busy = ($urandom_range(0, 2) == 0);
        else                    out_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        driveInputs();
    endtask

    task automatic pushPkt(input int r, input int nBody);
        flit_t bodyCodes [6];
        bodyCodes = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
        fq[r].push_back(3'b001);
        for (int b = 0; b < nBody; b++) fq[r].push_back(bodyCodes[$urandom_range(0, 5)]);
        fq[r].push_back(3'b110);
        driveInputs();
    endtask

    task automatic discardPkt(input int r);
        flit_t t;
        while (fq[r].size() > 0) begin
            t = fq[r].pop_front();
            if (t == 3'b110) break;
        end
    endtask

    task automatic resetModel();
        owner = -1;
        lastServed = 3;
        selHeld = 0;
        stall = 0;
        terrExp = 1'b0;
        prevGrant = 1'b0;
    endtask

    // Compare every DUT output against what the packet-level model says this cycle must show.
    task automatic checkOutput();
        int expReq;
        int expRd;
        expReq = (owner >= 0 && !fifo_empty[owner]) ? 1 : 0;
        expRd  = (expReq == 1 && !out_busy) ? (1 << owner) : 0;
        checkVal("grant_valid", int'(grant_valid), (owner >= 0) ? 1 : 0);
        checkVal("out_sel", int'(out_sel), selHeld);
        checkVal("out_req", int'(out_req), expReq);
        checkVal("fifo_rd", int'(fifo_rd), expRd);
        checkVal("timeout_err", int'(timeout_err), int'(terrExp));
    endtask

    // Move the model across the coming rising edge and consume the flit the arbiter must read.
    task automatic advanceModel();
        bit    terrNext;
        flit_t h;
        terrNext = 1'b0;
        if (owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (lastServed + k) % 4;
                if (!fifo_empty[c] && fifo_head[3*c +: 3] == 3'b001) begin
                    owner = c;
                    selHeld = c;
                    stall = 0;
                    modelLog.push_back(c);
                    break;
                end
            end
        end else if (!fifo_empty[owner] && !out_busy) begin
            h = fifo_head[3*owner +: 3];
            void'(fq[owner].pop_front());
            stall = 0;
            if (h == 3'b110) begin
                lastServed = owner;
                owner = -1;
            end
        end else begin
`ifdef I1_ROUTER_ARB_TIMEOUT_EN
            stall++;
            if (stall == TB_TIMEOUT) begin
                terrNext = 1'b1;
                lastServed = owner;
                discardPkt(owner);
                owner = -1;
                stall = 0;
            end
`endif
        end
        terrExp = terrNext;
    endtask

    // Per-cycle compare process plus a few DUT-side observation counters.
    always @(negedge clk) begin
        if (!rst) begin
            resetModel();
        end else begin
            checkOutput();
            for (int i = 0; i < 4; i++) if (fifo_rd[i]) rdCount[i]++;
            if (grant_valid && !prevGrant) grantLog.push_back(int'(out_sel));
            prevGrant = grant_valid;
            if (timeout_err) timeoutSeen++;
            advanceModel();
        end
    end

    task automatic waitDrained(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            done = (fq[0].size() == 0) && (fq[1].size() == 0) && (fq[2].size() == 0) &&
                   (fq[3].size() == 0) && (owner < 0) && !grant_valid;
            n++;
            tick();
        end
        checkVal({"drain_", name}, int'(done), 1);
    endtask

    task automatic waitRd(input int r, input int target, input int budget);
        int n;
        n = 0;
        while (rdCount[r] < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            tick();
        end
        checkVal("wait_read", (rdCount[r] >= target) ? 1 : 0, 1);
    endtask

    task automatic applyStimulus();
        int base;

        // Reset state.
        rst = 1'b0;
        driveInputs();
        @(negedge clk);
        #1;
        checkVal("rst_fifo_rd", int'(fifo_rd), 0);
        checkVal("rst_out_req", int'(out_req), 0);
        checkVal("rst_grant", int'(grant_valid), 0);
        checkVal("rst_out_sel", int'(out_sel), 0);
        checkVal("rst_timeout_err", int'(timeout_err), 0);
        tick();
        rst = 1'b1;
        tick();

        // Single packet on requester 0: grant one cycle after the head shows, three back-to-back reads.
        pushPkt(0, 1);
        @(negedge clk); #1;
        checkVal("single_arb_latency", int'(grant_valid), 0);
        tick();
        @(negedge clk); #1;
        checkVal("single_grant", int'(grant_valid), 1);
        checkVal("single_sel", int'(out_sel), 0);
        checkVal("single_rd_head", int'(fifo_rd), 1);
        tick();
        @(negedge clk); #1;
        checkVal("single_rd_body", int'(fifo_rd), 1);
        tick();
        @(negedge clk); #1;
        checkVal("single_rd_tail", int'(fifo_rd), 1);
        tick();
        @(negedge clk); #1;
        checkVal("single_idle_after_tail", int'(grant_valid), 0);
        tick();

        // Backpressure mid-packet on requester 1.
        base = rdCount[1];
        pushPkt(1, 2);
        waitRd(1, base + 1, 20);
        busyMode = 2;
        driveInputs();
        for (int k = 0; k < BP_CYCLES; k++) begin
            @(negedge clk); #1;
            checkVal("bp_out_req", int'(out_req), 1);
            checkVal("bp_fifo_rd", int'(fifo_rd), 0);
            checkVal("bp_grant", int'(grant_valid), 1);
            if (k == BP_CYCLES - 1) busyMode = 0;
            tick();
        end
        waitDrained("backpressure", 50);
        checkVal("bp_flit_count", rdCount[1] - base, 4);

        // A body flit at the front of requester 2 must not win the output.
        base = rdCount[2];
        fq[2].push_back(3'b010);
        driveInputs();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checkVal("nonhead_grant", int'(grant_valid), 0);
            tick();
        end
        checkVal("nonhead_reads", rdCount[2] - base, 0);
        fq[2].delete();
        driveInputs();
        tick();

        // Reset in the middle of a packet; the leftover body flits must never be read.
        base = rdCount[0];
        pushPkt(0, 3);
        waitRd(0, base + 2, 20);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkVal("midrst_fifo_rd", int'(fifo_rd), 0);
        checkVal("midrst_out_req", int'(out_req), 0);
        checkVal("midrst_grant", int'(grant_valid), 0);
        tick();
        tick();
        rst = 1'b1;
        base = rdCount[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checkVal("postrst_grant", int'(grant_valid), 0);
            tick();
        end
        checkVal("postrst_reads", rdCount[0] - base, 0);
        for (int r = 0; r < 4; r++) fq[r].delete();
        driveInputs();
        tick();

        // Contention right after reset: ptr starts at 3, so the order must be 0,1,2,3.
        grantLog.delete();
        modelLog.delete();
        for (int r = 0; r < 4; r++) pushPkt(r, 1);
        waitDrained("contention", 100);
        checkVal("contention_count", grantLog.size(), 4);
        checkVal("contention_model_count", modelLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grantLog.size()) checkVal("contention_order", grantLog[i], i);
            if (i < modelLog.size()) checkVal("contention_model_order", modelLog[i], i);
        end

`ifdef I1_ROUTER_ARB_TIMEOUT_EN
        // Requester 1 stalls after its head is read; the forced release hands the output to requester 2.
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        grantLog.delete();
        base = timeoutSeen;
        fq[1].push_back(3'b001);
        pushPkt(2, 0);
        waitDrained("timeout", 60);
        checkVal("timeout_pulses", timeoutSeen - base, 1);
        checkVal("timeout_grants", grantLog.size(), 2);
        if (grantLog.size() >= 2) begin
            checkVal("timeout_first", grantLog[0], 1);
            checkVal("timeout_next", grantLog[1], 2);
        end
`endif

        // Randomized traffic with FIFO gaps and backpressure.
        hideMode = 1;
        busyMode = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 4; r++) begin
                if ($urandom_range(0, 7) == 0 && fq[r].size() < 10) pushPkt(r, $urandom_range(0, 3));
            end
            tick();
        end
        hideMode = 0;
        busyMode = 0;
        driveInputs();
        waitDrained("random", 3000);
    endtask

    initial begin
        rst = 1'b0;
        fifo_empty = 4'hF;
        fifo_head = '0;
        out_busy = 1'b0;
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
